// File: rtl/parking_slot_ledger_if.sv
// -----------------------------------------------------------------------------
// parking_slot_ledger_if
// Request/response bundle between the slot selector/keypad decoder (master)
// and the parking slot ledger (slave).
//   timer      master->slave  free-running time base
//   in_req     master->slave  check-in request pulse
//   in_slot    master->slave  slot to check in
//   out_req    master->slave  check-out request pulse
//   out_slot   master->slave  slot to check out
//   in_ack     slave->master  check-in accepted pulse
//   in_err     slave->master  check-in rejected pulse
//   in_granted slave->master  slot written, valid with in_ack
//   out_valid  slave->master  check-out accepted pulse
//   out_err    slave->master  check-out rejected pulse
//   duration   slave->master  parked time, valid with out_valid
//   occupied   slave->master  bit k-1 set = slot k occupied
//   free_count slave->master  number of unoccupied slots
//   full       slave->master  no free slot left
// -----------------------------------------------------------------------------
interface parking_slot_ledger_if #(
    parameter int NUM_SLOTS = 6,
    parameter int TIME_W    = 11,
    parameter int SEL_W     = 4
);
    logic [TIME_W-1:0]    timer;
    logic                 in_req;
    logic [SEL_W-1:0]     in_slot;
    logic                 out_req;
    logic [SEL_W-1:0]     out_slot;
    logic                 in_ack;
    logic                 in_err;
    logic [SEL_W-1:0]     in_granted;
    logic                 out_valid;
    logic                 out_err;
    logic [TIME_W-1:0]    duration;
    logic [NUM_SLOTS-1:0] occupied;
    logic [SEL_W-1:0]     free_count;
    logic                 full;

    modport master (
        output timer, in_req, in_slot, out_req, out_slot,
        input  in_ack, in_err, in_granted, out_valid, out_err,
        input  duration, occupied, free_count, full
    );

    modport slave (
        input  timer, in_req, in_slot, out_req, out_slot,
        output in_ack, in_err, in_granted, out_valid, out_err,
        output duration, occupied, free_count, full
    );
endinterface

// File: rtl/parking_slot_ledger.sv
// -----------------------------------------------------------------------------
// parking_slot_ledger
// Keeps one check-in timestamp and one occupied flag per parking slot.
// Check-in stores the current timer value; check-out returns the elapsed
// time (modulo 2**TIME_W) and frees the slot. Free-slot count and full flag
// are maintained for the gate/display logic. All responses are registered
// one-cycle pulses answering the request sampled on the previous edge.
//
// Ports:
//   clk    system clock, all state on rising edge
//   reset  synchronous active-high reset
//   bus    parking_slot_ledger_if.slave (requests in, responses/status out)
//
// Optional feature macro: CHECKIN_AUTO_ASSIGN_EN
//   defined   : in_slot == 0 picks the lowest-numbered free slot
//   undefined : in_slot == 0 is rejected like any out-of-range slot
// -----------------------------------------------------------------------------
module parking_slot_ledger #(
    parameter int NUM_SLOTS = 6,
    parameter int TIME_W    = 11,
    parameter int SEL_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    parking_slot_ledger_if.slave   bus
);

    // One-hot select of a slot number; out-of-range numbers give all zeros.
    function automatic logic [NUM_SLOTS-1:0] slot_decode(input logic [SEL_W-1:0] slot);
        logic [NUM_SLOTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot == SEL_W'(i + 1)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Keep only the lowest set bit of a vector.
    function automatic logic [NUM_SLOTS-1:0] lowest_one(input logic [NUM_SLOTS-1:0] vec);
        logic [NUM_SLOTS-1:0] oh;
        logic                 found;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (vec[i] && !found) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // One-hot select back to a 1-based slot number.
    function automatic logic [SEL_W-1:0] slot_encode(input logic [NUM_SLOTS-1:0] oh);
        logic [SEL_W-1:0] num;
        num = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (oh[i]) begin
                num = num | SEL_W'(i + 1);
            end else begin
                num = num;
            end
        end
        return num;
    endfunction

    logic [TIME_W-1:0]    stamp_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] occupied_r;
    logic [SEL_W-1:0]     free_count_r;
    logic                 full_r;
    logic                 in_ack_r;
    logic                 in_err_r;
    logic [SEL_W-1:0]     in_granted_r;
    logic                 out_valid_r;
    logic                 out_err_r;
    logic [TIME_W-1:0]    duration_r;

    logic [NUM_SLOTS-1:0] in_sel_s;
    logic [NUM_SLOTS-1:0] out_sel_s;
    logic                 in_ok_s;
    logic                 out_ok_s;
    logic [TIME_W-1:0]    out_stamp_s;
    logic [NUM_SLOTS-1:0] occupied_next_s;
    logic [SEL_W-1:0]     free_next_s;

    // Judge both requests against pre-edge occupancy and form next state.
    always_comb begin
        in_sel_s = slot_decode(bus.in_slot);
`ifdef CHECKIN_AUTO_ASSIGN_EN
        // Auto-assign only sees pre-edge occupancy, so a slot freed by a
        // same-cycle check-out is not a candidate.
        if (bus.in_slot == {SEL_W{1'b0}}) begin
            in_sel_s = lowest_one(~occupied_r);
        end else begin
            in_sel_s = slot_decode(bus.in_slot);
        end
`endif
        out_sel_s = slot_decode(bus.out_slot);

        // A free target is required; same-slot collisions resolve naturally
        // because the check-out target must be occupied.
        in_ok_s  = bus.in_req  && ((in_sel_s  & ~occupied_r) != '0);
        out_ok_s = bus.out_req && ((out_sel_s &  occupied_r) != '0);

        out_stamp_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (out_sel_s[i]) begin
                out_stamp_s = out_stamp_s | stamp_r[i];
            end else begin
                out_stamp_s = out_stamp_s;
            end
        end

        occupied_next_s = occupied_r;
        if (out_ok_s) begin
            occupied_next_s = occupied_next_s & ~out_sel_s;
        end else begin
            occupied_next_s = occupied_next_s;
        end
        if (in_ok_s) begin
            occupied_next_s = occupied_next_s | in_sel_s;
        end else begin
            occupied_next_s = occupied_next_s;
        end

        free_next_s = free_count_r
                    + (out_ok_s ? SEL_W'(1) : SEL_W'(0))
                    - (in_ok_s  ? SEL_W'(1) : SEL_W'(0));
    end

    // Ledger state and registered response pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stamp_r[i] <= {TIME_W{1'b0}};
            end
            occupied_r   <= {NUM_SLOTS{1'b0}};
            free_count_r <= SEL_W'(NUM_SLOTS);
            full_r       <= 1'b0;
            in_ack_r     <= 1'b0;
            in_err_r     <= 1'b0;
            in_granted_r <= {SEL_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_err_r    <= 1'b0;
            duration_r   <= {TIME_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (in_ok_s && in_sel_s[i]) begin
                    stamp_r[i] <= bus.timer;
                end else begin
                    stamp_r[i] <= stamp_r[i];
                end
            end
            occupied_r   <= occupied_next_s;
            free_count_r <= free_next_s;
            full_r       <= (free_next_s == {SEL_W{1'b0}});
            in_ack_r     <= in_ok_s;
            in_err_r     <= bus.in_req && !in_ok_s;
            out_valid_r  <= out_ok_s;
            out_err_r    <= bus.out_req && !out_ok_s;
            if (in_ok_s) begin
                in_granted_r <= slot_encode(in_sel_s);
            end else begin
                in_granted_r <= in_granted_r;
            end
            // Subtraction in TIME_W bits gives the correct elapsed time
            // across a timer wrap.
            if (out_ok_s) begin
                duration_r <= bus.timer - out_stamp_s;
            end else begin
                duration_r <= duration_r;
            end
        end
    end

    assign bus.in_ack     = in_ack_r;
    assign bus.in_err     = in_err_r;
    assign bus.in_granted = in_granted_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_err    = out_err_r;
    assign bus.duration   = duration_r;
    assign bus.occupied   = occupied_r;
    assign bus.free_count = free_count_r;
    assign bus.full       = full_r;

endmodule
